// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU. It holds the architectural register file,
// accepts decoded instructions over valid/ready, and resolves the A/B/C
// operands with forwarding from the ALU result and from writeback. The
// operand bundle it hands to the ALU is registered.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_*                 decoded instruction (valid/ready handshake)
//   flush                drop the held bundle, refuse this cycle's instruction
//   alu_*  (out)         registered operand bundle, valid/ready to the ALU
//   alu_result           combinational ALU output for the bundle on alu_*
//   wb_en/addr/data      register-file writeback port
module alu_operand_stage #(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned OP_W    = 5,
    parameter int unsigned SHIFT_W = 4,
    parameter int unsigned AW      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_opcode,
    input  logic [AW-1:0]      in_ra,
    input  logic [AW-1:0]      in_rb,
    input  logic [AW-1:0]      in_rc,
    input  logic [WORD_W-1:0]  in_imm,
    input  logic               in_imm_sel,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic [AW-1:0]      in_rd,
    input  logic               in_wr_en,
    input  logic               flush,
    output logic               alu_valid,
    input  logic               alu_ready,
    output logic [OP_W-1:0]    alu_opcode,
    output logic [WORD_W-1:0]  alu_A,
    output logic [WORD_W-1:0]  alu_B,
    output logic [WORD_W-1:0]  alu_C,
    output logic [SHIFT_W-1:0] alu_shift,
    output logic [AW-1:0]      alu_rd,
    output logic               alu_wr_en,
    input  logic [WORD_W-1:0]  alu_result,
    input  logic               wb_en,
    input  logic [AW-1:0]      wb_addr,
    input  logic [WORD_W-1:0]  wb_data
);

    localparam int unsigned NREG = 1 << AW;

    logic [WORD_W-1:0] rf [NREG];

    logic              accept_c;
    logic              consume_c;
    logic              fwd_en_c;
    logic [WORD_W-1:0] opa_c;
    logic [WORD_W-1:0] opb_c;
    logic [WORD_W-1:0] opc_c;

    // Handshake: the slot is free when empty or being drained this cycle.
    assign in_ready  = rst_n & ~flush & (~alu_valid | alu_ready);
    assign accept_c  = in_valid & in_ready;
    assign consume_c = alu_valid & alu_ready;
    // The bundle leaving now will write back next cycle; its result is the
    // freshest value for alu_rd.
    assign fwd_en_c  = consume_c & alu_wr_en;

    // Operand priority: r0, ALU result, same-cycle writeback, file.
    function automatic logic [WORD_W-1:0] resolve(
        input logic [AW-1:0]     addr,
        input logic              fwd_en,
        input logic [AW-1:0]     fwd_addr,
        input logic [WORD_W-1:0] fwd_data,
        input logic              wbk_en,
        input logic [AW-1:0]     wbk_addr,
        input logic [WORD_W-1:0] wbk_data,
        input logic [WORD_W-1:0] rf_data
    );
        logic [WORD_W-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else if (fwd_en && (fwd_addr == addr)) begin
            val = fwd_data;
        end else if (wbk_en && (wbk_addr == addr)) begin
            val = wbk_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Operand selection for the instruction currently offered.
    always_comb begin
        opa_c = resolve(in_ra, fwd_en_c, alu_rd, alu_result,
                        wb_en, wb_addr, wb_data, rf[in_ra]);
        opc_c = resolve(in_rc, fwd_en_c, alu_rd, alu_result,
                        wb_en, wb_addr, wb_data, rf[in_rc]);
        if (in_imm_sel) begin
            opb_c = in_imm;
        end else begin
            opb_c = resolve(in_rb, fwd_en_c, alu_rd, alu_result,
                            wb_en, wb_addr, wb_data, rf[in_rb]);
        end
    end

    // Register file; r0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[AW'(i)] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Bundle register: load on accept, drop on drain or flush, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_valid  <= 1'b0;
            alu_opcode <= '0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_C      <= '0;
            alu_shift  <= '0;
            alu_rd     <= '0;
            alu_wr_en  <= 1'b0;
        end else if (flush) begin
            alu_valid  <= 1'b0;
        end else if (accept_c) begin
            alu_valid  <= 1'b1;
            alu_opcode <= in_opcode;
            alu_A      <= opa_c;
            alu_B      <= opb_c;
            alu_C      <= opc_c;
            alu_shift  <= in_shift;
            alu_rd     <= in_rd;
            alu_wr_en  <= in_wr_en;
        end else if (consume_c) begin
            alu_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    typedef struct packed {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [3:0]  sh;
        logic [3:0]  rd;
        logic        we;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [3:0]  in_ra, in_rb, in_rc, in_rd;
    logic [15:0] in_imm;
    logic        in_imm_sel;
    logic [3:0]  in_shift;
    logic        in_wr_en;
    logic        flush;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_A, alu_B, alu_C;
    logic [3:0]  alu_shift;
    logic [3:0]  alu_rd;
    logic        alu_wr_en;
    logic [15:0] alu_result;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;

    int checks = 0;
    int errors = 0;
    bundle_t exp_q[$];

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_imm(in_imm),
        .in_imm_sel(in_imm_sel), .in_shift(in_shift), .in_rd(in_rd),
        .in_wr_en(in_wr_en), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_opcode(alu_opcode),
        .alu_A(alu_A), .alu_B(alu_B), .alu_C(alu_C), .alu_shift(alu_shift),
        .alu_rd(alu_rd), .alu_wr_en(alu_wr_en), .alu_result(alu_result),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        wb_en    = 1'b0;
    endtask

    task automatic wb(input logic [3:0] addr, input logic [15:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
    endtask

    // Offer an instruction and queue the bundle it must produce.
    task automatic issue(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic sel, input logic [15:0] imm,
                         input logic [3:0] sh, input logic [3:0] rd, input logic we,
                         input logic [15:0] ea, input logic [15:0] eb, input logic [15:0] ec);
        bundle_t e;
        in_valid   = 1'b1;
        in_opcode  = op;
        in_ra      = ra;
        in_rb      = rb;
        in_rc      = rc;
        in_imm_sel = sel;
        in_imm     = imm;
        in_shift   = sh;
        in_rd      = rd;
        in_wr_en   = we;
        e = '{op: op, a: ea, b: eb, c: ec, sh: sh, rd: rd, we: we};
        exp_q.push_back(e);
    endtask

    // Monitor: every bundle the ALU consumes is compared with the oldest expected one.
    always @(negedge clk) begin
        bundle_t got;
        bundle_t e;
        if (rst_n && alu_valid && alu_ready) begin
            got = '{op: alu_opcode, a: alu_A, b: alu_B, c: alu_C,
                    sh: alu_shift, rd: alu_rd, we: alu_wr_en};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bundle: unexpected bundle %h, none expected", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL bundle: op=%h A=%h B=%h C=%h sh=%h rd=%h we=%b expected op=%h A=%h B=%h C=%h sh=%h rd=%h we=%b",
                             got.op, got.a, got.b, got.c, got.sh, got.rd, got.we,
                             e.op, e.a, e.b, e.c, e.sh, e.rd, e.we);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; idle(); alu_ready = 1'b1; alu_result = '0;
        in_opcode = '0; in_ra = '0; in_rb = '0; in_rc = '0; in_rd = '0;
        in_imm = '0; in_imm_sel = 1'b0; in_shift = '0; in_wr_en = 1'b0;
        wb_addr = '0; wb_data = '0;
        step(); step();
        check("rst_valid", 16'(alu_valid), 16'h0);
        check("rst_ready", 16'(in_ready), 16'h0);
        check("rst_A", alu_A, 16'h0);
        rst_n = 1'b1;
        #1 check("ready_after_rst", 16'(in_ready), 16'h1);

        // 1: file read after a writeback
        wb(4'd3, 16'h1234); step(); idle();
        issue(5'd1, 4'd3, 4'd0, 4'd0, 1'b0, 16'h0, 4'd2, 4'd1, 1'b0, 16'h1234, 16'h0, 16'h0);
        step();
        check("valid_after_accept", 16'(alu_valid), 16'h1);

        // 2: back-to-back ALU forward, then writeback bypass
        issue(5'd2, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd5, 1'b1, 16'h0, 16'h0, 16'h0);
        step();
        alu_result = 16'h0042;
        issue(5'd3, 4'd5, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd6, 1'b0, 16'h0042, 16'h0, 16'h0);
        #1 check("ready_b2b_1", 16'(in_ready), 16'h1);
        step();
        alu_result = 16'h0099; wb(4'd5, 16'h0042);
        issue(5'd4, 4'd5, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd7, 1'b0, 16'h0042, 16'h0, 16'h0);
        #1 check("ready_b2b_2", 16'(in_ready), 16'h1);
        step(); idle();

        // 3: stall holds the bundle and blocks input
        issue(5'd5, 4'd5, 4'd3, 4'd0, 1'b0, 16'h0, 4'd1, 4'd8, 1'b1, 16'h0042, 16'h1234, 16'h0);
        step();
        alu_ready = 1'b0;
        in_valid = 1'b1; in_ra = 4'd8; in_rb = 4'd3; in_rc = 4'd5;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_ready", 16'(in_ready), 16'h0);
            check("stall_A", alu_A, 16'h0042);
            check("stall_B", alu_B, 16'h1234);
            step();
        end
        alu_ready = 1'b1; alu_result = 16'h0777;
        issue(5'd6, 4'd8, 4'd3, 4'd5, 1'b0, 16'h0, 4'd3, 4'd9, 1'b0, 16'h0777, 16'h1234, 16'h0042);
        step(); idle();
        wb(4'd8, 16'h0777); step(); idle();

        // 4: immediate overrides a pending forward on rb
        issue(5'd7, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd5, 1'b1, 16'h0, 16'h0, 16'h0);
        step();
        alu_result = 16'h5555;
        issue(5'd8, 4'd3, 4'd5, 4'd5, 1'b1, 16'h7FFF, 4'd4, 4'd9, 1'b0, 16'h1234, 16'h7FFF, 16'h5555);
        step(); idle();
        wb(4'd5, 16'h5555); step(); idle();

        // 5: r0 ignores writes and is never forwarded
        wb(4'd0, 16'hFFFF); step(); idle();
        issue(5'd9, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd0, 1'b1, 16'h0, 16'h0, 16'h0);
        step();
        alu_result = 16'hBEEF;
        issue(5'd10, 4'd0, 4'd0, 4'd5, 1'b0, 16'h0, 4'd0, 4'd1, 1'b0, 16'h0, 16'h0, 16'h5555);
        step(); idle();
        wb(4'd0, 16'hBEEF); step(); idle();
        issue(5'd11, 4'd0, 4'd8, 4'd0, 1'b0, 16'h0, 4'd0, 4'd1, 1'b0, 16'h0, 16'h0777, 16'h0);
        step(); idle();
        step();

        // 6: flush drops the held bundle but keeps the writeback
        issue(5'd12, 4'd3, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd1, 1'b0, 16'h1234, 16'h0, 16'h0);
        step();
        alu_ready = 1'b0; flush = 1'b1; wb(4'd2, 16'h00AA);
        in_valid = 1'b1; in_ra = 4'd3; in_opcode = 5'd13;
        void'(exp_q.pop_back());
        #1 check("flush_ready", 16'(in_ready), 16'h0);
        step(); idle(); alu_ready = 1'b1;
        check("flush_valid", 16'(alu_valid), 16'h0);
        step();
        check("flush_no_accept", 16'(alu_valid), 16'h0);
        issue(5'd14, 4'd2, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd1, 1'b0, 16'h00AA, 16'h0, 16'h0);
        step(); idle();

        // Reset during a stall clears the bundle and the file
        issue(5'd15, 4'd2, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd1, 1'b0, 16'h00AA, 16'h0, 16'h0);
        step(); idle();
        alu_ready = 1'b0;
        step();
        check("stall_before_rst", 16'(alu_valid), 16'h1);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        step();
        check("rst_mid_valid", 16'(alu_valid), 16'h0);
        check("rst_mid_A", alu_A, 16'h0);
        rst_n = 1'b1; alu_ready = 1'b1;
        issue(5'd16, 4'd2, 4'd0, 4'd0, 1'b0, 16'h0, 4'd0, 4'd1, 1'b0, 16'h0, 16'h0, 16'h0);
        step(); idle();
        step(); step();

        check("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the fixed-point/integer ALU.
- Holds the 16x16 architectural register file and accepts decoded instructions over a valid/ready handshake.
- Reads operands, resolving RAW hazards by forwarding the ALU's combinational result and the writeback value.
- Presents a registered operand bundle (opcode, A, B, C, shift, destination) to the ALU.

Parameters:
WORD_W, 16, datapath word width (matches REG_WORD_LEN)
OP_W, 5, opcode width (matches ALU_MODE_LEN)
SHIFT_W, 4, shift-amount width (matches SHIFT_LEN)
AW, 4, register address width; register count = 2**AW

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  decoder has an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_opcode  in  OP_W  ALU opcode
in_ra  in  AW  source register for A
in_rb  in  AW  source register for B
in_rc  in  AW  source register for C
in_imm  in  WORD_W  immediate value
in_imm_sel  in  1  1: B = in_imm, rb ignored
in_shift  in  SHIFT_W  shift amount
in_rd  in  AW  destination register
in_wr_en  in  1  instruction writes rd
flush  in  1  discard the held instruction (branch taken)
alu_valid  out  1  operand bundle valid
alu_ready  in  1  downstream consumes the bundle this cycle
alu_opcode  out  OP_W  registered opcode
alu_A  out  WORD_W  registered operand A
alu_B  out  WORD_W  registered operand B
alu_C  out  WORD_W  registered operand C
alu_shift  out  SHIFT_W  registered shift amount
alu_rd  out  AW  registered destination
alu_wr_en  out  1  registered write enable
alu_result  in  WORD_W  ALU output for the current bundle, combinational
wb_en  in  1  writeback strobe
wb_addr  in  AW  writeback register
wb_data  in  WORD_W  writeback value

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All registers clear to 0, including all file entries.
  - alu_valid=0 and all alu_* data outputs = 0.
  - in_ready is low while rst_n=0.
- Handshake:
  - in_ready = rst_n & !flush & (!alu_valid | alu_ready).
  - Accept = in_valid & in_ready. On accept, the bundle is captured and alu_valid=1 next cycle.
  - Latency is 1 cycle from accept to bundle presentation.
  - If alu_valid & alu_ready & !accept, alu_valid clears next cycle.
  - If alu_valid & !alu_ready, all alu_* outputs hold stable.
- Flush:
  - alu_valid clears next cycle and in_ready is forced low.
  - The decoder instruction offered that cycle is not accepted.
  - The register-file write from wb_* still occurs.
- Register file:
  - Register 0 always reads 0; writes to register 0 are ignored.
  - Write on wb_en at the clock edge.
- Downstream contract: a bundle consumed at cycle t (alu_valid & alu_ready) returns its result on wb_* at cycle t+1 when alu_wr_en=1. The stage relies on this; no interlock exists.
- Operand resolution, evaluated independently for ra, rb and rc at accept, first match wins:
  1. Address 0 -> 0.
  2. alu_valid & alu_ready & alu_wr_en & alu_rd==addr -> alu_result.
  3. wb_en & wb_addr==addr -> wb_data (same-cycle write bypass).
  4. Register-file contents.
- Operand B: if in_imm_sel=1, B = in_imm and rb forwarding is not evaluated. A and C are still resolved from ra and rc.
- Simultaneous events:
  - Accept and consume in the same cycle: the new bundle replaces the old with no bubble. Throughput is 1 instruction per cycle.
  - wb write and read of the same address in the same cycle: the read returns the new data.
- Widths: all data paths are WORD_W with no arithmetic. Forwarded values pass through unmodified (saturation is the ALU's concern).
- The stage never mutates a held bundle while alu_valid=1 & alu_ready=0. Forwarded values are captured only at accept.

Test Plan:
1. Reset, then write r3=0x1234 via wb, then issue ra=3, rb=0, imm_sel=0 -> one cycle after accept: alu_A=0x1234, alu_B=0x0000, alu_valid=1.
2. Back-to-back: issue rd=5 (alu_result=0x0042 while consumed), then next-cycle issue ra=5 -> second bundle alu_A=0x0042. Third instruction reading r5 one cycle later gets wb_data=0x0042 via bypass. in_ready stays 1 throughout.
3. Stall: alu_valid=1, alu_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 for those cycles and alu_* stable. alu_ready=1 -> next instruction captured the following cycle.
4. Immediate: in_imm_sel=1, in_imm=0x7FFF, rb=5 with a pending r5 forward -> alu_B=0x7FFF; A and C resolve normally.
5. r0 protection: wb_en=1, wb_addr=0, wb_data=0xFFFF, then issue ra=0 -> alu_A=0x0000. Also an in-flight bundle with alu_rd=0 is not forwarded.
6. Flush with in_valid=1 and wb_en=1 (r2=0x00AA) -> alu_valid=0 next cycle and the instruction is not accepted. A later read of r2 returns 0x00AA. Asserting rst_n=0 mid-stall clears alu_valid and r2 to 0.
